// File: rtl/cello_tt_sweep_ctrl_if.sv
// Connection bundle for cello_tt_sweep_ctrl: the start/busy/done/pass/tt
// handshake with the test controller plus the three driven inputs and the
// single sampled output of the combinational logic block under test.
interface cello_tt_sweep_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] tt;
    logic       dut_in1;
    logic       dut_in2;
    logic       dut_in3;
    logic       dut_out;

    // Environment side: test controller issuing start, logic block returning dut_out.
    modport master (
        output start, dut_out,
        input  busy, done, pass, tt, dut_in1, dut_in2, dut_in3
    );

    // Sweep controller side.
    modport slave (
        input  start, dut_out,
        output busy, done, pass, tt, dut_in1, dut_in2, dut_in3
    );
endinterface

// File: rtl/cello_tt_sweep_ctrl.sv
// Truth-table sweep controller: drives all eight vectors into a 3-input
// combinational block, holds each for SETTLE_CYCLES before sampling its
// output, assembles the measured table (bit 7-r = row r) and compares it
// with EXPECTED_TT.
// Optional macro CELLO_SWEEP_GRAY_EN: visit rows in Gray order
// 0,1,3,2,6,7,5,4 so only one input toggles per step.
module cello_tt_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  EXPECTED_TT   = 8'h79,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cello_tt_sweep_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

`ifdef CELLO_SWEEP_GRAY_EN
    localparam logic [2:0] LAST_ROW = 3'd4;
`else
    localparam logic [2:0] LAST_ROW = 3'd7;
`endif

    // Row that follows r in the visiting order.
    function automatic logic [2:0] next_row(input logic [2:0] r);
`ifdef CELLO_SWEEP_GRAY_EN
        logic [2:0] b;
        // Gray -> binary sequence index, step it, then back to Gray.
        b = {r[2], ^r[2:1], ^r};
        b = b + 3'd1;
        return b ^ (b >> 1);
`else
        return r + 3'd1;
`endif
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tt_q, tt_d;
    logic             pass_q, pass_d;

    // Next-state logic: sequencing, settle counting, sampling and verdict.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = APPLY;
                    row_d   = 3'd0;
                    cnt_d   = '0;
                    tt_d    = 8'h00;
                    pass_d  = 1'b0;
                end
            end
            APPLY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // Row r lands in bit 7-r, i.e. the bitwise complement of r.
                tt_d[~row_q] = bus.dut_out;
                cnt_d        = '0;
                if (row_q == LAST_ROW) begin
                    state_d = DONE;
                    // Verdict uses the table including this final sample so it
                    // is already valid while done is high.
                    pass_d  = (tt_d == EXPECTED_TT);
                end else begin
                    state_d = APPLY;
                    row_d   = next_row(row_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= 3'd0;
            cnt_q   <= '0;
            tt_q    <= 8'h00;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.busy    = (state_q == APPLY) || (state_q == SAMPLE);
    assign bus.done    = (state_q == DONE);
    assign bus.pass    = pass_q;
    assign bus.tt      = tt_q;
    assign bus.dut_in1 = row_q[2];
    assign bus.dut_in2 = row_q[1];
    assign bus.dut_in3 = row_q[0];

endmodule

// File: tb/tb_cello_tt_sweep_ctrl.sv
// Bench for cello_tt_sweep_ctrl: two instances (default parameters, and
// SETTLE_CYCLES=1 / EXPECTED_TT=0x96) each attached to a table-driven model
// of the logic block. Cycle 1 of a sweep is the cycle in which start is high.
module tb_cello_tt_sweep_ctrl;
    localparam int         S_A   = 4;
    localparam int         S_B   = 1;
    localparam logic [7:0] EXP_A = 8'h79;
    localparam logic [7:0] EXP_B = 8'h96;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cello_tt_sweep_ctrl_if ifa();
    cello_tt_sweep_ctrl_if ifb();

    cello_tt_sweep_ctrl #(.SETTLE_CYCLES(S_A), .EXPECTED_TT(EXP_A), .CNT_W(8))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    cello_tt_sweep_ctrl #(.SETTLE_CYCLES(S_B), .EXPECTED_TT(EXP_B), .CNT_W(8))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    logic       start_w [2];
    logic [7:0] net_w   [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic       pass_w  [2];
    logic [7:0] tt_w    [2];
    logic [2:0] vec_w   [2];
    logic [2:0] prev_v  [2];
    logic       glitch_en;
    logic       noise;

    int ncmp  = 0;
    int nfail = 0;

    assign ifa.start = start_w[0];
    assign ifb.start = start_w[1];
    assign busy_w[0] = ifa.busy;
    assign busy_w[1] = ifb.busy;
    assign done_w[0] = ifa.done;
    assign done_w[1] = ifb.done;
    assign pass_w[0] = ifa.pass;
    assign pass_w[1] = ifb.pass;
    assign tt_w[0]   = ifa.tt;
    assign tt_w[1]   = ifb.tt;
    assign vec_w[0]  = {ifa.dut_in1, ifa.dut_in2, ifa.dut_in3};
    assign vec_w[1]  = {ifb.dut_in1, ifb.dut_in2, ifb.dut_in3};

    // Logic-block models: output = table bit (7-row). Instance A also glitches
    // randomly in the cycle right after its inputs change.
    always @(posedge clk) begin
        prev_v[0] <= vec_w[0];
        prev_v[1] <= vec_w[1];
    end
    always @(negedge clk) noise <= 1'($urandom_range(0, 1));
    assign ifa.dut_out = net_w[0][~vec_w[0]] ^ (glitch_en & (vec_w[0] != prev_v[0]) & noise);
    assign ifb.dut_out = net_w[1][~vec_w[1]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int w, input string tag);
        check({tag, ".busy"}, 32'(busy_w[w]), 32'(0));
        check({tag, ".done"}, 32'(done_w[w]), 32'(0));
        check({tag, ".pass"}, 32'(pass_w[w]), 32'(0));
        check({tag, ".tt"},   32'(tt_w[w]),   32'(0));
        check({tag, ".vec"},  32'(vec_w[w]),  32'(0));
    endtask

    // i-th row of the visiting order.
    function automatic logic [2:0] exp_row(input int i);
`ifdef CELLO_SWEEP_GRAY_EN
        return 3'(i ^ (i >> 1));
`else
        return 3'(i);
`endif
    endfunction

    // Truth table (row 0 in the MSB) of 3-input parity, optionally inverted.
    function automatic logic [7:0] parity_table(input logic invert);
        logic [7:0] t;
        for (int r = 0; r < 8; r++) begin
            t[3'(7 - r)] = ((($countones(3'(r))) % 2) == 1) ^ invert;
        end
        return t;
    endfunction

    // One sweep on instance w with network table net. Optional extra start
    // pulses in cycles rs1/rs2, optional reset in cycle rst_at (0 = none).
    task automatic sweep(input int w, input logic [7:0] net,
                         input int rs1, input int rs2, input int rst_at);
        int         lat, done_cnt, done_cyc, last, busy_drop;
        logic       exp_pass;
        logic       aborted;
        logic [2:0] order[$];
        lat       = 1 + 8 * ((w == 0 ? S_A : S_B) + 1) + 1;
        exp_pass  = (net == (w == 0 ? EXP_A : EXP_B));
        net_w[w]  = net;
        done_cnt  = 0;
        done_cyc  = 0;
        busy_drop = 0;
        last      = -1;
        aborted   = 1'b0;
        @(negedge clk);
        start_w[w] = 1'b1;
        for (int c = 2; c <= lat + 3; c++) begin
            @(negedge clk);
            start_w[w] = (c == rs1) || (c == rs2);
            if (rst_at != 0 && c == rst_at + 1) begin
                start_w[w] = 1'b0;
                check_reset(w, "rst_mid");
                rst     = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (rst_at != 0 && c == rst_at) rst = 1'b1;
            if (busy_w[w] && int'(vec_w[w]) != last) begin
                order.push_back(vec_w[w]);
                last = int'(vec_w[w]);
            end
            if (c < lat && !busy_w[w]) busy_drop++;
            if (done_w[w]) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = c;
                    check("busy_at_done", 32'(busy_w[w]), 32'(0));
                    check("tt_at_done",   32'(tt_w[w]),   32'(net));
                    check("pass_at_done", 32'(pass_w[w]), 32'(exp_pass));
                end
            end
        end
        start_w[w] = 1'b0;
        if (!aborted) begin
            check("latency",    32'(done_cyc),  32'(lat));
            check("done_count", 32'(done_cnt),  32'(1));
            check("busy_drop",  32'(busy_drop), 32'(0));
            check("tt_hold",    32'(tt_w[w]),   32'(net));
            check("pass_hold",  32'(pass_w[w]), 32'(exp_pass));
            check("rows_seen",  32'(order.size()), 32'(8));
            for (int i = 0; i < order.size() && i < 8; i++) begin
                check("row_order", 32'(order[i]), 32'(exp_row(i)));
`ifdef CELLO_SWEEP_GRAY_EN
                if (i > 0) check("gray_step", 32'($countones(order[i] ^ order[i-1])), 32'(1));
`endif
            end
        end
    endtask

    initial begin
        logic [7:0] net;
        rst        = 1'b1;
        start_w[0] = 1'b0;
        start_w[1] = 1'b0;
        net_w[0]   = 8'h79;
        net_w[1]   = 8'h96;
        glitch_en  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset(0, "reset_a");
        check_reset(1, "reset_b");
        rst       = 1'b0;
        glitch_en = 1'b1;

        // Correct 0x79 network: 42-cycle sweep, pass.
        sweep(0, 8'h79, 0, 0, 0);
        // Output stuck at 1.
        sweep(0, 8'hFF, 0, 0, 0);
        // Extra start pulses mid-sweep are ignored.
        sweep(0, 8'h79, 5, 20, 0);
        // Reset mid-sweep, then a clean sweep.
        sweep(0, 8'h79, 0, 0, 15);
        sweep(0, 8'h79, 0, 0, 0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst        = 1'b1;
        start_w[0] = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        start_w[0] = 1'b0;
        check_reset(0, "rst_vs_start");
        @(negedge clk);
        check("rst_vs_start.idle", 32'(busy_w[0]), 32'(0));

        // Short settle instance: complemented parity matches 0x96, plain XOR3
        // (0x69 in this bit order) does not.
        sweep(1, parity_table(1'b1), 0, 0, 0);
        sweep(1, parity_table(1'b0), 0, 0, 0);

        // Random networks, sometimes the expected one.
        repeat (6) begin
            net = ($urandom_range(0, 2) == 0) ? EXP_A : 8'($urandom);
            sweep(0, net, 0, 0, 0);
        end
        repeat (4) begin
            net = ($urandom_range(0, 2) == 0) ? EXP_B : 8'($urandom);
            sweep(1, net, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
